// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : op-code and width constants shared by the ALU, decode and control
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_ABJ  = 4'b1010;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_shifter.sv
// ============================================================================
// alu_shifter : single right barrel shifter; left shifts reuse it by bit-reversal
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_shifter #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [SHW-1:0]  shamt_i,
  input  logic            dir_i,     // 1 = left, 0 = right
  input  logic            arith_i,   // sign fill on right shifts
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0]   w_data_rev;
  logic [XLEN-1:0]   w_shr_in;
  logic [XLEN-1:0]   w_shr;
  logic [XLEN-1:0]   w_shr_rev;
  logic              w_fill;
  logic signed [XLEN:0] w_ext;

  generate
    for (genvar i = 0; i < XLEN; i++) begin : g_rev
      assign w_data_rev[i] = data_i[XLEN-1-i];
      assign w_shr_rev[i]  = w_shr[XLEN-1-i];
    end
  endgenerate

  assign w_shr_in = dir_i ? w_data_rev : data_i;
  // Fill bit rides above the MSB so one arithmetic shift covers both fills
  assign w_fill   = arith_i & ~dir_i & data_i[XLEN-1];
  assign w_ext    = {w_fill, w_shr_in};
  assign w_shr    = XLEN'(w_ext >>> shamt_i);

  assign result_o = dir_i ? w_shr_rev : w_shr;

endmodule : alu_shifter

`default_nettype wire

// File: rtl/rv32_alu.sv
// ============================================================================
// rv32_alu : RV32 execute-stage ALU, 11 ops plus zero flag
// Optional output register enabled by defining ALU_OUT_REG_EN
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rv32_alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] src_A,
  input  logic [XLEN-1:0] src_B,
  input  logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] result_d;
  logic [XLEN-1:0] w_shift;
  logic            w_slt;
  logic            w_sltu;

  assign w_slt  = $signed(src_A) < $signed(src_B);
  assign w_sltu = src_A < src_B;

  alu_shifter #(.XLEN(XLEN)) u_shifter (
    .data_i   (src_A),
    .shamt_i  (src_B[SHW-1:0]),
    .dir_i    (alu_op == ALU_SLL),
    .arith_i  (alu_op == ALU_SRA),
    .result_o (w_shift)
  );

  always_comb begin
    result_d = '0;
    case (alu_op)
      ALU_ADD:                   result_d = src_A + src_B;
      ALU_SUB:                   result_d = src_A - src_B;
      ALU_AND:                   result_d = src_A & src_B;
      ALU_OR:                    result_d = src_A | src_B;
      ALU_XOR:                   result_d = src_A ^ src_B;
      ALU_SLT:                   result_d = {{(XLEN-1){1'b0}}, w_slt};
      ALU_SLTU:                  result_d = {{(XLEN-1){1'b0}}, w_sltu};
      ALU_SLL, ALU_SRL, ALU_SRA: result_d = w_shift;
      ALU_ABJ:                   result_d = src_A & ~src_B;
      default:                   result_d = '0;  // NOP and reserved codes
    endcase
  end

`ifdef ALU_OUT_REG_EN
  logic [XLEN-1:0] result_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) result_q <= '0;
    else          result_q <= result_d;
  end

  // zero comes from the registered value so it always tracks alu_result
  assign alu_result = result_q;
  assign zero       = ~|result_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset_n;

  assign alu_result = result_d;
  assign zero       = ~|result_d;
`endif

endmodule : rv32_alu

`default_nettype wire

// File: tb/tb_rv32_alu.sv
// ============================================================================
// tb_rv32_alu : directed self-checking bench for rv32_alu (either build)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_rv32_alu;

  logic        clk;
  logic        reset_n;
  logic [31:0] src_A;
  logic [31:0] src_B;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        zero;

  int n_cmp  = 0;
  int n_fail = 0;

  rv32_alu dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .src_A      (src_A),
    .src_B      (src_B),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp_res, input logic exp_zero);
    n_cmp++;
    assert (alu_result === exp_res) else begin
      n_fail++;
      $error("FAIL %s result: got %08h expected %08h", tag, alu_result, exp_res);
    end
    n_cmp++;
    assert (zero === exp_zero) else begin
      n_fail++;
      $error("FAIL %s zero: got %0b expected %0b", tag, zero, exp_zero);
    end
  endtask

  // Drive on the falling edge; sample 1 time unit after the capturing edge
  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op = op;
    src_A  = a;
    src_B  = b;
`ifdef ALU_OUT_REG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    alu_op  = 4'b0000;
    src_A   = 32'd1000;
    src_B   = 32'd2000;
`ifdef ALU_OUT_REG_EN
    #2;
    check("reset_async", 32'h0, 1'b1);
`endif
    #12;
    reset_n = 1'b1;

`ifdef ALU_OUT_REG_EN
    apply(4'b0000, 32'd1000, 32'd2000);
    check("reg_add_latency", 32'd3000, 1'b0);
`endif

    apply(4'b0000, 32'd1972, 32'd1121);          check("add", 32'd3093, 1'b0);
    apply(4'b0000, 32'hFFFF_FFFF, 32'h1);        check("add_wrap", 32'h0, 1'b1);
    apply(4'b0001, 32'd30, 32'd30);              check("sub_zero", 32'h0, 1'b1);
    apply(4'b0001, 32'd10, 32'd20);              check("sub_neg", 32'hFFFF_FFF6, 1'b0);
    apply(4'b0010, 32'hF0F0_F0F0, 32'h0F0F_0F0F); check("and", 32'h0, 1'b1);
    apply(4'b0011, 32'h7777_7777, 32'hEF07_189A); check("or", 32'hFF77_7FFF, 1'b0);
    apply(4'b0100, 32'hFFFF_FFFF, 32'h0F0F_0F0F); check("xor", 32'hF0F0_F0F0, 1'b0);
    apply(4'b1010, 32'hFFFF_FFFF, 32'h7812_AEB5); check("abj", 32'h87ED_514A, 1'b0);
    apply(4'b0101, 32'h0, 32'hF000_0001);        check("slt_neg_b", 32'h0, 1'b1);
    apply(4'b0101, 32'd1121, 32'd1972);          check("slt_pos", 32'h1, 1'b0);
    apply(4'b0101, 32'h8000_0000, 32'h7FFF_FFFF); check("slt_minmax", 32'h1, 1'b0);
    apply(4'b0110, 32'hF000_0000, 32'hF000_0001); check("sltu_lt", 32'h1, 1'b0);
    apply(4'b0110, 32'd31011, 32'd31011);        check("sltu_eq", 32'h0, 1'b1);
    apply(4'b0110, 32'h0000_0001, 32'h8000_0000); check("sltu_big_b", 32'h1, 1'b0);
    apply(4'b0111, 32'h1234_5679, 32'd31);       check("sll_31", 32'h8000_0000, 1'b0);
    apply(4'b0111, 32'h0F0F_FF00, 32'd1972);     check("sll_hiB", 32'hF000_0000, 1'b0);
    apply(4'b0111, 32'h0000_0001, 32'd31011);    check("sll_by3", 32'h0000_0008, 1'b0);
    apply(4'b0111, 32'hA5A5_A5A5, 32'd0);        check("sll_0", 32'hA5A5_A5A5, 1'b0);
    apply(4'b1000, 32'hFFFF_FFFF, 32'd1972);     check("srl_hiB", 32'h0000_0FFF, 1'b0);
    apply(4'b1000, 32'h8000_0000, 32'd31);       check("srl_31", 32'h0000_0001, 1'b0);
    apply(4'b1001, 32'hFDEA_DBEF, 32'd4);        check("sra_neg", 32'hFFDE_ADBE, 1'b0);
    apply(4'b1001, 32'h8000_0000, 32'd1972);     check("sra_hiB", 32'hFFFF_F800, 1'b0);
    apply(4'b1001, 32'h7FFF_FFFF, 32'd4);        check("sra_pos", 32'h07FF_FFFF, 1'b0);
    apply(4'b1111, 32'hDEAD_BEEF, 32'hCAFE_BEBE); check("nop", 32'h0, 1'b1);
    for (int op = 11; op <= 14; op++) begin
      apply(4'(op), 32'hDEAD_BEEF, 32'hCAFE_BEBE);
      check($sformatf("reserved_%0d", op), 32'h0, 1'b1);
    end

`ifdef ALU_OUT_REG_EN
    apply(4'b0000, 32'd1000, 32'd2000);          check("reg_pre_reset", 32'd3000, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("reg_mid_reset", 32'h0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    apply(4'b0100, 32'h0000_00FF, 32'h0000_000F); check("reg_after_reset", 32'h0000_00F0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_rv32_alu

`default_nettype wire
